// File: rtl/demux_serial_dispatcher_if.sv
// demux_serial_dispatcher_if: producer-side bus of the serial dispatcher.
//   master (producer) drives data_in/dest/load and observes the rest.
//   slave (dispatcher) drives ready, sel0/sel1, ser_out, bit_valid, done.
interface demux_serial_dispatcher_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] data_in;
    logic [1:0]       dest;
    logic             load;
    logic             ready;
    logic             sel0;
    logic             sel1;
    logic             ser_out;
    logic             bit_valid;
    logic             done;
    modport master (
        output data_in, dest, load,
        input  ready, sel0, sel1, ser_out, bit_valid, done
    );
    modport slave (
        input  data_in, dest, load,
        output ready, sel0, sel1, ser_out, bit_valid, done
    );
endinterface

// File: rtl/demux_serial_dispatcher.sv
// demux_serial_dispatcher: serialises a WIDTH-bit word LSB first toward a 1-to-4 demux.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   bus (slave)  : data_in/dest/load in; ready, sel0/sel1, ser_out, bit_valid, done out
//   DISPATCH_PARITY_EN : when defined, an even-parity bit follows the data bits.
// Every output is a register loaded from the current state, so each output
// trails the FSM state by one cycle (ready stays high the cycle after a capture).
module demux_serial_dispatcher #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    demux_serial_dispatcher_if.slave bus
);
`ifdef DISPATCH_PARITY_EN
    localparam int LEN = WIDTH + 1;
`else
    localparam int LEN = WIDTH;
`endif
    localparam int CW = $clog2(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LEN-1:0] shreg_q, shreg_d, frame;
    logic [1:0]     sel_q, sel_d;
    logic           ready_q, ready_d;
    logic           ser_out_q, ser_out_d;
    logic           bit_valid_q, bit_valid_d;
    logic           done_q, done_d;
    logic           accept, last;
`ifdef DISPATCH_PARITY_EN
    assign frame = {^bus.data_in, bus.data_in};
`else
    assign frame = bus.data_in;
`endif
    assign accept = (state_q == IDLE) && bus.load;
    assign last   = (cnt_q == LAST);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            sel_q       <= '0;
            ready_q     <= 1'b1;
            ser_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            sel_q       <= sel_d;
            ready_q     <= ready_d;
            ser_out_q   <= ser_out_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
        end
    end
    always_comb begin
        state_d = (state_q == IDLE)  ? (bus.load ? SHIFT : IDLE) :
                  (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end
    always_comb begin
        shreg_d     = accept ? frame : (state_q == SHIFT) ? (shreg_q >> 1) : shreg_q;
        cnt_d       = (state_q == SHIFT && !last) ? cnt_q + CW'(1) : '0;
        sel_d       = accept ? bus.dest : sel_q;
        ready_d     = (state_q == IDLE);
        bit_valid_d = (state_q == SHIFT);
        ser_out_d   = (state_q == SHIFT) && shreg_q[0];
        done_d      = (state_q == DONE);
    end
    assign bus.ready     = ready_q;
    assign bus.sel0      = sel_q[1];
    assign bus.sel1      = sel_q[0];
    assign bus.ser_out   = ser_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_demux_serial_dispatcher.sv
// tb_demux_serial_dispatcher: directed self-checking bench for demux_serial_dispatcher.
module tb_demux_serial_dispatcher;
`ifdef DISPATCH_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    logic clk;
    logic reset;
    int   passes;
    int   total;
    demux_serial_dispatcher_if #(.WIDTH(8)) bus ();
    demux_serial_dispatcher #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_idle(input string tag, input logic [1:0] s);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_sel"}, 32'({bus.sel0, bus.sel1}), 32'(s));
        chk({tag, "_ser"}, 32'(bus.ser_out), 32'd0);
        chk({tag, "_bv"}, 32'(bus.bit_valid), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask
    task automatic frame_bits(input logic [8:0] e, input logic [1:0] s, input bit noisy, input string tag);
        for (int i = 0; i < NB; i++) begin
            step();
            chk($sformatf("%s_ser%0d", tag, i), 32'(bus.ser_out), 32'(e[i]));
            chk($sformatf("%s_bv%0d", tag, i), 32'(bus.bit_valid), 32'd1);
            chk($sformatf("%s_sel%0d", tag, i), 32'({bus.sel0, bus.sel1}), 32'(s));
            chk($sformatf("%s_rdy%0d", tag, i), 32'(bus.ready), 32'd0);
            chk($sformatf("%s_dn%0d", tag, i), 32'(bus.done), 32'd0);
            if (noisy) begin
                bus.load    = ~bus.load;
                bus.data_in = ~bus.data_in;
                bus.dest    = ~bus.dest;
            end
        end
    endtask
    task automatic frame_end(input logic [1:0] s, input string tag);
        step();
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_done_bv"}, 32'(bus.bit_valid), 32'd0);
        chk({tag, "_done_ser"}, 32'(bus.ser_out), 32'd0);
        chk({tag, "_done_rdy"}, 32'(bus.ready), 32'd0);
        chk({tag, "_done_sel"}, 32'({bus.sel0, bus.sel1}), 32'(s));
        bus.load = 1'b0;
        step();
        chk_idle({tag, "_after"}, s);
    endtask
    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic [8:0] e, input string tag);
        bus.data_in = d;
        bus.dest    = s;
        bus.load    = 1'b1;
        step();
        chk({tag, "_cap_sel"}, 32'({bus.sel0, bus.sel1}), 32'(s));
        bus.load = 1'b0;
        frame_bits(e, s, 1'b0, tag);
        frame_end(s, tag);
    endtask
    initial begin
        passes      = 0;
        total       = 0;
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.data_in = 8'h00;
        bus.dest    = 2'd0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_idle($sformatf("idle%0d", i), 2'b00);
        end
        send(8'hA5, 2'd2, 9'h0A5, "a5");
        bus.data_in = 8'hFF;
        bus.dest    = 2'd0;
        bus.load    = 1'b1;
        step();
        chk("b2b_cap1_sel", 32'({bus.sel0, bus.sel1}), 32'd0);
        bus.data_in = 8'h01;
        bus.dest    = 2'd3;
        frame_bits(9'h0FF, 2'b00, 1'b0, "ff");
        step();
        chk("b2b_done1", 32'(bus.done), 32'd1);
        chk("b2b_done1_sel", 32'({bus.sel0, bus.sel1}), 32'd0);
`ifdef DISPATCH_PARITY_EN
        step();
`endif
        step();
        chk("b2b_cap2_sel", 32'({bus.sel0, bus.sel1}), 32'd3);
        chk("b2b_cap2_done", 32'(bus.done), 32'd0);
        chk("b2b_cap2_bv", 32'(bus.bit_valid), 32'd0);
        bus.load = 1'b0;
        frame_bits(9'h101, 2'b11, 1'b0, "01");
        frame_end(2'b11, "01");
        bus.data_in = 8'h3C;
        bus.dest    = 2'd1;
        bus.load    = 1'b1;
        step();
        chk("3c_cap_sel", 32'({bus.sel0, bus.sel1}), 32'd1);
        bus.load = 1'b0;
        frame_bits(9'h03C, 2'b01, 1'b1, "3c");
        frame_end(2'b01, "3c");
        step();
        chk_idle("3c_noacc", 2'b01);
        send(8'hF0, 2'd2, 9'h0F0, "f0_pre");
        bus.data_in = 8'hF0;
        bus.dest    = 2'd2;
        bus.load    = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("f0_bv%0d", i), 32'(bus.bit_valid), 32'd1);
        end
        reset = 1'b1;
        step();
        chk_idle("midrst", 2'b00);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle($sformatf("postrst%0d", i), 2'b00);
        end
        send(8'h0F, 2'd3, 9'h00F, "0f");
        reset       = 1'b1;
        bus.load    = 1'b1;
        bus.data_in = 8'hAA;
        bus.dest    = 2'd1;
        step();
        chk_idle("rstload", 2'b00);
        reset    = 1'b0;
        bus.load = 1'b0;
        step();
        chk_idle("rstload_after", 2'b00);
`ifdef DISPATCH_PARITY_EN
        send(8'h07, 2'd3, 9'h107, "par07");
`endif
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
